// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: fetch-side direction prediction from a
// table of 2-bit saturating counters, EX-stage outcome resolution,
// registered one-cycle redirect on misprediction, and table training.
module branch_resolver #(
   parameter int unsigned BHT_ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rst_n,

   // fetch side
   input  logic [31:0] if_pc,
   input  logic        if_B_type,
   input  logic        if_jal,
   input  logic [31:0] if_imme,
   output logic        pred_taken,
   output logic [31:0] pred_target,

   // execute side
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_B_type,
   input  logic        ex_jal,
   input  logic        ex_jalr,
   input  logic [2:0]  ex_func3,
   input  logic [31:0] ex_rs1_data,
   input  logic [31:0] ex_rs2_data,
   input  logic [31:0] ex_imme,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,

   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
);

   localparam int unsigned IDX_W   = $clog2(BHT_ENTRIES);
   localparam logic [1:0]  CNT_RST = 2'b01;
   localparam logic [1:0]  CNT_MAX = 2'b11;
   localparam logic [1:0]  CNT_MIN = 2'b00;

   localparam logic [2:0]  F3_BEQ  = 3'b000;
   localparam logic [2:0]  F3_BNE  = 3'b001;
   localparam logic [2:0]  F3_BLT  = 3'b100;
   localparam logic [2:0]  F3_BGE  = 3'b101;
   localparam logic [2:0]  F3_BLTU = 3'b110;
   localparam logic [2:0]  F3_BGEU = 3'b111;

   logic [1:0]       bht [BHT_ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;

   logic             cond_known;
   logic             cond_true;
   logic             is_branch;
   logic             is_jump;
   logic             live;
   logic             taken;
   logic [31:0]      seq_pc;
   logic [31:0]      target;
   logic [31:0]      next_pc;
   logic             mispredict;
   logic             bht_we;
   logic [1:0]       bht_cur;
   logic [1:0]       bht_nxt;

   assign if_idx = if_pc[IDX_W+1:2];
   assign ex_idx = ex_pc[IDX_W+1:2];

   // Fetch prediction: reads the pre-update counter, no bypass from EX.
   always_comb begin
      pred_taken  = if_jal | (if_B_type & bht[if_idx][1]);
      pred_target = pred_taken ? (if_pc + if_imme) : (if_pc + 32'd4);
   end

   // Branch condition evaluation; func3 010/011 are not branches.
   always_comb begin
      cond_known = 1'b1;
      cond_true  = 1'b0;
      unique case (ex_func3)
         F3_BEQ:  cond_true = (ex_rs1_data == ex_rs2_data);
         F3_BNE:  cond_true = (ex_rs1_data != ex_rs2_data);
         F3_BLT:  cond_true = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
         F3_BGE:  cond_true = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
         F3_BLTU: cond_true = (ex_rs1_data <  ex_rs2_data);
         F3_BGEU: cond_true = (ex_rs1_data >= ex_rs2_data);
         default: cond_known = 1'b0;
      endcase
   end

   // Resolve outcome, correct next PC and misprediction for the EX slot.
   always_comb begin
      is_jump   = ex_jal | ex_jalr;
      is_branch = ex_B_type & ~is_jump & cond_known;
      // The EX slot during a redirect cycle is wrong-path and is dropped.
      live      = ex_valid & ~redirect & (is_branch | is_jump);
      taken     = is_jump | (is_branch & cond_true);
      seq_pc    = ex_pc + 32'd4;
      if (ex_jalr) begin
         target = (ex_rs1_data + ex_imme) & 32'hFFFF_FFFE;
      end else begin
         target = ex_pc + ex_imme;
      end
      next_pc    = taken ? target : seq_pc;
      mispredict = (taken != ex_pred_taken) |
                   (taken & (target != ex_pred_target));
   end

   // Saturating counter update for a live conditional branch.
   always_comb begin
      bht_we  = live & is_branch;
      bht_cur = bht[ex_idx];
      bht_nxt = bht_cur;
      if (taken) begin
         if (bht_cur != CNT_MAX) begin
            bht_nxt = bht_cur + 2'd1;
         end
      end else begin
         if (bht_cur != CNT_MIN) begin
            bht_nxt = bht_cur - 2'd1;
         end
      end
   end

   // Redirect pulse, redirect target and statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect         <= 1'b0;
         redirect_pc      <= 32'd0;
         stat_branches    <= 32'd0;
         stat_mispredicts <= 32'd0;
      end else begin
         redirect <= live & mispredict;
         if (live) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict) begin
               redirect_pc      <= next_pc;
               stat_mispredicts <= stat_mispredicts + 32'd1;
            end
         end
      end
   end

   // Prediction table storage; single write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= CNT_RST;
         end
      end else if (bht_we) begin
         bht[ex_idx] <= bht_nxt;
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: reset, training, compares, jumps,
// squash, non-branch func3, predict/update collision and async reset.
module tb_branch_resolver;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_B_type;
   logic        if_jal;
   logic [31:0] if_imme;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_B_type;
   logic        ex_jal;
   logic        ex_jalr;
   logic [2:0]  ex_func3;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imme;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int errors = 0;
   int checks = 0;

   branch_resolver #(.BHT_ENTRIES(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_B_type        (if_B_type),
      .if_jal           (if_jal),
      .if_imme          (if_imme),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_B_type        (ex_B_type),
      .ex_jal           (ex_jal),
      .ex_jalr          (ex_jalr),
      .ex_func3         (ex_func3),
      .ex_rs1_data      (ex_rs1_data),
      .ex_rs2_data      (ex_rs2_data),
      .ex_imme          (ex_imme),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a conditional branch in EX.
   task automatic ex_br(input logic [31:0] pc, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
      ex_valid = 1'b1; ex_pc = pc; ex_B_type = 1'b1; ex_jal = 1'b0; ex_jalr = 1'b0;
      ex_func3 = f3; ex_rs1_data = rs1; ex_rs2_data = rs2; ex_imme = imm;
      ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   // Present a jal (isjalr=0) or jalr (isjalr=1) in EX.
   task automatic ex_jmp(input logic isjalr, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
      ex_valid = 1'b1; ex_pc = pc; ex_B_type = 1'b0; ex_jal = ~isjalr; ex_jalr = isjalr;
      ex_func3 = 3'b000; ex_rs1_data = rs1; ex_rs2_data = 32'd0; ex_imme = imm;
      ex_pred_taken = pt; ex_pred_target = ptgt;
   endtask

   task automatic ex_idle();
      ex_valid = 1'b0; ex_B_type = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
   endtask

   task automatic probe(input logic [31:0] pc, input string tag, input logic exp);
      if_pc = pc; if_B_type = 1'b1; if_jal = 1'b0;
      #1;
      chk(tag, 32'(pred_taken), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0;
      if_pc = 32'd0; if_B_type = 1'b0; if_jal = 1'b0; if_imme = 32'd0;
      ex_pc = 32'd0; ex_func3 = 3'd0; ex_rs1_data = 32'd0; ex_rs2_data = 32'd0;
      ex_imme = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
      ex_idle();
      #12;

      // ---- reset state
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_branches", stat_branches, 32'd0);
      chk("rst_mispredicts", stat_mispredicts, 32'd0);
      probe(32'h100, "rst_pred_100", 1'b0);
      probe(32'h3FC, "rst_pred_3fc", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---- training at pc 0x100
      if_pc = 32'h100; if_B_type = 1'b1; if_imme = 32'h40;
      ex_br(32'h100, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 32'h104);
      #1;
      chk("train_pred_before", 32'(pred_taken), 32'd0);
      tick();
      chk("train1_redirect", 32'(redirect), 32'd1);
      chk("train1_redirect_pc", redirect_pc, 32'h140);
      chk("train1_pred_taken", 32'(pred_taken), 32'd1);
      chk("train1_pred_target", pred_target, 32'h140);
      ex_idle();
      tick();
      chk("train_bubble_redirect", 32'(redirect), 32'd0);
      ex_br(32'h100, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 32'h104);
      tick();
      chk("train2_redirect", 32'(redirect), 32'd1);
      chk("train2_redirect_pc", redirect_pc, 32'h140);
      ex_idle();
      tick();
      ex_br(32'h100, 3'b000, 32'd5, 32'd5, 32'h40, 1'b1, 32'h140);
      tick();
      chk("train3_redirect", 32'(redirect), 32'd0);
      chk("train3_branches", stat_branches, 32'd3);
      chk("train3_mispredicts", stat_mispredicts, 32'd2);
      chk("train3_pred_taken", 32'(pred_taken), 32'd1);
      // Not-taken step from a saturated 11 lands on 10: still predicts taken.
      ex_br(32'h100, 3'b000, 32'd5, 32'd6, 32'h40, 1'b1, 32'h140);
      tick();
      chk("sat_nt_redirect", 32'(redirect), 32'd1);
      chk("sat_nt_redirect_pc", redirect_pc, 32'h104);
      chk("sat_pred_taken", 32'(pred_taken), 32'd1);
      chk("sat_branches", stat_branches, 32'd4);
      chk("sat_mispredicts", stat_mispredicts, 32'd3);
      ex_idle();
      tick();

      // ---- signed / unsigned compares
      ex_br(32'h204, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h208);
      tick();
      chk("blt_redirect", 32'(redirect), 32'd1);
      chk("blt_redirect_pc", redirect_pc, 32'h224);
      ex_idle();
      tick();
      ex_br(32'h208, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h228);
      tick();
      chk("bltu_redirect", 32'(redirect), 32'd1);
      chk("bltu_redirect_pc", redirect_pc, 32'h20C);
      chk("bltu_branches", stat_branches, 32'd6);
      chk("bltu_mispredicts", stat_mispredicts, 32'd5);
      ex_idle();
      tick();
      ex_br(32'h220, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h230);
      tick();
      chk("bge_redirect", 32'(redirect), 32'd0);
      ex_br(32'h224, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h234);
      tick();
      chk("bgeu_redirect", 32'(redirect), 32'd0);
      ex_br(32'h228, 3'b001, 32'd7, 32'd7, 32'h10, 1'b0, 32'h238);
      tick();
      chk("bne_redirect", 32'(redirect), 32'd0);
      chk("cmp_redirect_pc_held", redirect_pc, 32'h20C);
      chk("cmp_branches", stat_branches, 32'd9);
      chk("cmp_mispredicts", stat_mispredicts, 32'd5);

      // ---- jalr and jal
      ex_jmp(1'b1, 32'h300, 32'h2001, 32'h10, 1'b0, 32'h304);
      tick();
      chk("jalr_redirect", 32'(redirect), 32'd1);
      chk("jalr_redirect_pc", redirect_pc, 32'h2010);
      ex_idle();
      tick();
      ex_jmp(1'b0, 32'h600, 32'd0, 32'h100, 1'b1, 32'h700);
      tick();
      chk("jal_ok_redirect", 32'(redirect), 32'd0);
      ex_jmp(1'b0, 32'h600, 32'd0, 32'h100, 1'b1, 32'h704);
      tick();
      chk("jal_tgt_redirect", 32'(redirect), 32'd1);
      chk("jal_tgt_redirect_pc", redirect_pc, 32'h700);
      chk("jal_branches", stat_branches, 32'd12);
      chk("jal_mispredicts", stat_mispredicts, 32'd7);
      ex_idle();
      if_pc = 32'h600; if_B_type = 1'b0; if_jal = 1'b1; if_imme = 32'h100;
      #1;
      chk("if_jal_pred", 32'(pred_taken), 32'd1);
      chk("if_jal_target", pred_target, 32'h700);
      if_jal = 1'b0;
      #1;
      chk("if_none_target", pred_target, 32'h604);
      tick();

      // ---- squash of the EX slot during a redirect cycle
      ex_br(32'h40C, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 32'h410);
      tick();
      chk("sq1_redirect", 32'(redirect), 32'd1);
      chk("sq1_redirect_pc", redirect_pc, 32'h44C);
      ex_br(32'h410, 3'b000, 32'd5, 32'd5, 32'h80, 1'b0, 32'h414);
      tick();
      chk("sq2_redirect", 32'(redirect), 32'd0);
      chk("sq2_redirect_pc", redirect_pc, 32'h44C);
      chk("sq2_branches", stat_branches, 32'd13);
      chk("sq2_mispredicts", stat_mispredicts, 32'd8);
      ex_idle();
      probe(32'h410, "sq2_bht_unchanged", 1'b0);
      probe(32'h40C, "sq1_bht_trained", 1'b1);

      // ---- func3 010 / 011 are not branches
      ex_br(32'h514, 3'b010, 32'd5, 32'd5, 32'h40, 1'b0, 32'h518);
      tick();
      chk("f010_redirect", 32'(redirect), 32'd0);
      ex_br(32'h514, 3'b011, 32'd5, 32'd5, 32'h40, 1'b0, 32'h518);
      tick();
      chk("f011_redirect", 32'(redirect), 32'd0);
      chk("f01x_branches", stat_branches, 32'd13);
      ex_idle();
      probe(32'h514, "f01x_bht_unchanged", 1'b0);

      // ---- same-cycle predict and update at one index
      if_pc = 32'h518; if_B_type = 1'b1; if_imme = 32'h40;
      ex_br(32'h518, 3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 32'h51C);
      #1;
      chk("same_idx_pred_old", 32'(pred_taken), 32'd0);
      tick();
      chk("same_idx_pred_new", 32'(pred_taken), 32'd1);
      chk("same_idx_redirect", 32'(redirect), 32'd1);
      chk("same_idx_redirect_pc", redirect_pc, 32'h558);
      chk("same_idx_branches", stat_branches, 32'd14);
      chk("same_idx_mispredicts", stat_mispredicts, 32'd9);

      // ---- async reset while redirect is high
      ex_idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_redirect", 32'(redirect), 32'd0);
      chk("arst_redirect_pc", redirect_pc, 32'd0);
      chk("arst_branches", stat_branches, 32'd0);
      chk("arst_mispredicts", stat_mispredicts, 32'd0);
      probe(32'h100, "arst_bht", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_redirect", 32'(redirect), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution and prediction-table owner. The fetch-side control-flow decoder classifies jal/jalr/conditional branches and supplies an immediate. This block:
- gives fetch its direction prediction from a table of 2-bit saturating counters;
- resolves the real outcome in EX;
- raises a registered one-cycle redirect on misprediction;
- trains the table.

## Interface
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, index = pc[log2(BHT_ENTRIES)+1:2]
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch PC
- if_B_type  in  1  fetched instruction is a conditional branch
- if_jal  in  1  fetched instruction is jal
- if_imme  in  32  immediate from fetch decoder
- pred_taken  out  1  combinational prediction for fetch
- pred_target  out  32  combinational predicted target for fetch
- ex_valid  in  1  EX holds a real instruction this cycle
- ex_pc  in  32  PC of EX instruction
- ex_B_type, ex_jal, ex_jalr  in  1 each  class of EX instruction
- ex_func3  in  3  branch condition code
- ex_rs1_data, ex_rs2_data  in  32  forwarded operands
- ex_imme  in  32  immediate (B, J or I format, already sign-extended)
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_pred_target  in  32  predicted target carried down the pipe
- redirect  out  1  registered one-cycle flush/redirect pulse
- redirect_pc  out  32  registered correct next PC
- stat_branches  out  32  resolved control-flow instruction count
- stat_mispredicts  out  32  misprediction count

## Operation
Prediction (combinational, fetch side):
- pred_taken = if_jal | (if_B_type & bht[idx(if_pc)][1]).
- pred_target = if_pc + if_imme when pred_taken, otherwise if_pc + 4.
- jalr is never predicted taken.

Resolution (EX):
- An instruction is live when `ex_valid & ~redirect` and it is one of: B_type with func3 in {000,001,100,101,110,111}, jal, or jalr.
- A B_type with func3 010 or 011 is treated as a non-branch: no redirect, no update, not counted.
- Conditions:
  - beq: equal; bne: not equal.
  - blt / bge: signed compare.
  - bltu / bgeu: unsigned compare.
  - jal and jalr: always taken.
- Actual target, all arithmetic mod 2^32:
  - B_type and jal: ex_pc + ex_imme.
  - jalr: (ex_rs1_data + ex_imme) & 0xFFFF_FFFE.
- Correct next PC = actual target when taken, otherwise ex_pc + 4.
- mispredict = (taken != ex_pred_taken) | (taken & (target != ex_pred_target)).

Registered effects at the next clock edge, for a live instruction only:
- redirect <= mispredict.
- redirect_pc <= correct next PC when mispredicted; redirect_pc holds its value otherwise.
- stat_branches += 1.
- stat_mispredicts += mispredict.
- Both counters wrap at 2^32.
- BHT update applies to live B_type only:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.

Squash:
- The cycle in which redirect = 1 contains a wrong-path EX instruction.
- That instruction is ignored: no redirect, no update, no count.
- Redirect therefore never lasts two consecutive cycles.

## Timing
- Reset (asynchronous, rst_n low):
  - redirect = 0, redirect_pc = 0.
  - Both stat counters = 0.
  - Every BHT entry = 01 (weakly not taken).
  - Reset mid-operation drops any pending redirect immediately.
- Prediction has zero latency: it is combinational from the if_* inputs and the current BHT state.
- Resolution latency is 1 cycle: an EX instruction at edge N produces redirect high during cycle N+1 → N+2.
- Same-cycle predict and update to the same index: the prediction uses the pre-update counter; there is no bypass.
- One update per cycle at most; the table is single-write.

## Test plan
- Reset: after rst_n low then high, redirect = 0, counters = 0, and pred_taken = 0 for if_B_type = 1 at any PC.
- Training:
  - Stimulus: three consecutive live beq at pc 0x100 with rs1 = rs2 = 5, imm = 0x40, ex_pred_taken = 0.
  - Required: the first two resolves give a redirect to 0x140 (01→10, 10→11).
  - Required: pred_taken for if_pc = 0x100 becomes 1 after the first update.
  - Required: the counter saturates at 11 after the second update.
  - Required: the third resolve, predicted taken to 0x140, gives no redirect.
  - Required: stat_branches = 3, stat_mispredicts = 2.
- Signed/unsigned compare:
  - blt with rs1 = 0xFFFF_FFFF, rs2 = 1 → taken.
  - bltu with the same operands → not taken; redirect_pc = pc + 4 when predicted taken.
- jalr:
  - Stimulus: rs1 = 0x2001, imm = 0x10, predicted not taken.
  - Required: redirect = 1, redirect_pc = 0x2010 (bit 0 cleared).
- Squash: a mispredicted branch followed next cycle by another mispredicted live branch → only one redirect pulse; the second instruction is not counted and the BHT is unchanged.
- Edge cases:
  - func3 = 010 B_type → no redirect, no count.
  - Simultaneous predict and update to the same index → prediction shows the old counter.
  - rst_n asserted while redirect = 1 → redirect drops immediately.
